// File: rtl/mc_controller.sv
// ----------------------------------------------------------------------------
// mc_controller
// Multicycle ARM main control FSM. Steps FETCH -> DECODE -> execute ->
// writeback and issues per-cycle datapath controls plus the unconditional
// write requests (PCS, RegW, MemW, FlagW). The conditional-execution logic
// downstream gates those requests with CondEx.
//
// Parameters
//   MEM_HANDSHAKE  1 = memory states wait for MemReady, 0 = never stall
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous reset, active-low
//   Op         in   instr[27:26]
//   Funct      in   instr[25:20]  (I=[5], cmd=[4:1], S/L=[0])
//   Rd         in   instr[15:12]
//   MemReady   in   memory has completed the current access this cycle
//   PCS        out  PC-write request (Branch | Rd==15 & RegW)
//   NextPC     out  PC+4 write enable
//   RegW       out  register-file write request
//   MemW       out  memory write request
//   FlagW      out  flag-write request, [1]=NZ, [0]=CV
//   IRWrite    out  instruction-register load
//   AdrSrc     out  0 = PC, 1 = ALU result
//   ResultSrc  out  00 ALUOut, 01 Data, 10 ALUResult
//   ALUSrcA    out  0 = RD1, 1 = PC
//   ALUSrcB    out  00 RD2, 01 Imm, 10 constant 4
//   ALUControl out  00 ADD, 01 SUB, 10 AND, 11 ORR
//   ImmSrc     out  equals Op
//   RegSrc     out  [0]=(Op==10), [1]=(Op==01)
// ----------------------------------------------------------------------------
module mc_controller #(
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic       MemReady,
    output logic       PCS,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic [1:0] FlagW,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic       w_mem_ready;
    logic       w_branch;
    logic [1:0] w_alu_ctl;
    logic       w_no_write;

    // Returns {ALUControl, NoWrite} for a data-processing cmd field.
    function automatic logic [2:0] alu_decode(input logic [3:0] cmd);
        case (cmd)
            4'b0100: alu_decode = {2'b00, 1'b0};  // ADD
            4'b0010: alu_decode = {2'b01, 1'b0};  // SUB
            4'b0000: alu_decode = {2'b10, 1'b0};  // AND
            4'b1100: alu_decode = {2'b11, 1'b0};  // ORR
            4'b1010: alu_decode = {2'b01, 1'b1};  // CMP: subtract, flags only
            default: alu_decode = {2'b00, 1'b1};  // unsupported: no result write
        endcase
    endfunction

    assign w_mem_ready             = MEM_HANDSHAKE ? MemReady : 1'b1;
    assign {w_alu_ctl, w_no_write} = alu_decode(Funct[4:1]);

    assign ImmSrc = Op;
    assign RegSrc = {(Op == 2'b01), (Op == 2'b10)};

    // Reset drops straight to FETCH, abandoning any access in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = S_FETCH;
        w_branch   = 1'b0;
        NextPC     = 1'b0;
        RegW       = 1'b0;
        MemW       = 1'b0;
        FlagW      = 2'b00;
        IRWrite    = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUControl = 2'b00;

        case (r_state)
            S_FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                // IR and PC only advance on the cycle the fetch completes
                IRWrite   = w_mem_ready;
                NextPC    = w_mem_ready;
                w_next    = w_mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (Op)
                    2'b01:   w_next = S_MEMADR;
                    2'b00:   w_next = Funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b10:   w_next = S_BRANCH;
                    default: w_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALUSrcB = 2'b01;
                w_next  = Funct[0] ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                w_next = w_mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegW      = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc = 1'b1;
                MemW   = 1'b1;
                w_next = w_mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECUTER, S_EXECUTEI: begin
                ALUSrcB    = (r_state == S_EXECUTEI) ? 2'b01 : 2'b00;
                ALUControl = w_alu_ctl;
                // CV flags only make sense for the arithmetic ops
                FlagW      = {Funct[0], Funct[0] & ~w_alu_ctl[1]};
                w_next     = S_ALUWB;
            end
            S_ALUWB: begin
                RegW = ~w_no_write;
            end
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                w_branch  = 1'b1;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase

        PCS = w_branch | ((Rd == 4'd15) & RegW);
    end

endmodule

// File: tb/tb_mc_controller.sv
module tb_mc_controller;

    typedef struct packed {
        logic       pcs;
        logic       nextpc;
        logic       regw;
        logic       memw;
        logic [1:0] flagw;
        logic       irw;
        logic       adrsrc;
        logic [1:0] ressrc;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] aluc;
        logic [1:0] imms;
        logic [1:0] regs;
    } out_t;

    typedef struct packed {
        out_t e;
        logic mr;
    } step_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] Op = 2'b00;
    logic [5:0] Funct = 6'd0;
    logic [3:0] Rd = 4'd0;
    logic       MemReady = 1'b1;

    logic       PCS, NextPC, RegW, MemW, IRWrite, AdrSrc, ALUSrcA;
    logic [1:0] FlagW, ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;

    logic       n_PCS, n_NextPC, n_RegW, n_MemW, n_IRWrite, n_AdrSrc, n_ALUSrcA;
    logic [1:0] n_FlagW, n_ResultSrc, n_ALUSrcB, n_ALUControl, n_ImmSrc, n_RegSrc;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mc_controller #(.MEM_HANDSHAKE(1'b1)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd),
        .MemReady(MemReady), .PCS(PCS), .NextPC(NextPC), .RegW(RegW),
        .MemW(MemW), .FlagW(FlagW), .IRWrite(IRWrite), .AdrSrc(AdrSrc),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegSrc(RegSrc)
    );

    mc_controller #(.MEM_HANDSHAKE(1'b0)) dut_nohs (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd),
        .MemReady(MemReady), .PCS(n_PCS), .NextPC(n_NextPC), .RegW(n_RegW),
        .MemW(n_MemW), .FlagW(n_FlagW), .IRWrite(n_IRWrite), .AdrSrc(n_AdrSrc),
        .ResultSrc(n_ResultSrc), .ALUSrcA(n_ALUSrcA), .ALUSrcB(n_ALUSrcB),
        .ALUControl(n_ALUControl), .ImmSrc(n_ImmSrc), .RegSrc(n_RegSrc)
    );

    out_t got, got_n;
    assign got   = '{PCS, NextPC, RegW, MemW, FlagW, IRWrite, AdrSrc, ResultSrc,
                     ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc};
    assign got_n = '{n_PCS, n_NextPC, n_RegW, n_MemW, n_FlagW, n_IRWrite, n_AdrSrc,
                     n_ResultSrc, n_ALUSrcA, n_ALUSrcB, n_ALUControl, n_ImmSrc, n_RegSrc};

    // ---------------- reference model ----------------
    function automatic out_t base(input logic [1:0] op);
        out_t o = '0;
        o.imms = op;
        o.regs = {op == 2'b01, op == 2'b10};
        return o;
    endfunction

    // Fetch / decode share "PC + 4 through the ALU" controls.
    function automatic out_t pc_plus4(input logic [1:0] op);
        out_t o = base(op);
        o.srca   = 1'b1;
        o.srcb   = 2'b10;
        o.ressrc = 2'b10;
        return o;
    endfunction

    // Data-processing command table: {ALUControl, NoWrite}.
    function automatic logic [2:0] dp_op(input logic [3:0] cmd);
        if (cmd == 4'b0100) return 3'b000;
        if (cmd == 4'b0010) return 3'b010;
        if (cmd == 4'b0000) return 3'b100;
        if (cmd == 4'b1100) return 3'b110;
        if (cmd == 4'b1010) return 3'b011;
        return 3'b001;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Builds the cycle-by-cycle expectation for one instruction, with
    // fstall fetch wait cycles and mstall data-memory wait cycles.
    task automatic build(input logic [1:0] op, input logic [5:0] fn, input logic [3:0] rd,
                         input int fstall, input int mstall, output step_t q[$]);
        out_t o;
        logic [2:0] d;
        q = {};
        for (int i = 0; i < fstall; i++) q.push_back('{pc_plus4(op), 1'b0});
        o = pc_plus4(op); o.irw = 1'b1; o.nextpc = 1'b1;
        q.push_back('{o, 1'b1});
        q.push_back('{pc_plus4(op), rbit()});
        if (op == 2'b10) begin
            o = base(op); o.srcb = 2'b01; o.ressrc = 2'b10; o.pcs = 1'b1;
            q.push_back('{o, rbit()});
        end else if (op == 2'b00) begin
            d = dp_op(fn[4:1]);
            o = base(op); o.srcb = fn[5] ? 2'b01 : 2'b00; o.aluc = d[2:1];
            o.flagw = {fn[0], fn[0] & (d[2:1] == 2'b00 || d[2:1] == 2'b01)};
            q.push_back('{o, rbit()});
            o = base(op); o.regw = ~d[0]; o.pcs = ~d[0] & (rd == 4'd15);
            q.push_back('{o, rbit()});
        end else if (op == 2'b01) begin
            o = base(op); o.srcb = 2'b01;
            q.push_back('{o, rbit()});
            o = base(op); o.adrsrc = 1'b1; o.memw = ~fn[0];
            for (int i = 0; i < mstall; i++) q.push_back('{o, 1'b0});
            q.push_back('{o, 1'b1});
            if (fn[0]) begin
                o = base(op); o.ressrc = 2'b01; o.regw = 1'b1; o.pcs = (rd == 4'd15);
                q.push_back('{o, rbit()});
            end
        end
    endtask

    // Runs one instruction from FETCH; called at posedge+1.
    task automatic run_instr(input string name, input logic [1:0] op, input logic [5:0] fn,
                             input logic [3:0] rd, input int fstall, input int mstall);
        step_t q[$];
        build(op, fn, rd, fstall, mstall, q);
        Op = op; Funct = fn; Rd = rd;
        for (int i = 0; i < q.size(); i++) begin
            MemReady = q[i].mr;
            @(negedge clk);
            n_tests++;
            if (got !== q[i].e) begin
                n_fail++;
                $display("FAIL %s cyc%0d got=%h exp=%h", name, i, got, q[i].e);
            end
            @(posedge clk); #1;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        out_t e;
        reset = 1'b0; Op = 2'b01; MemReady = 1'b1;
        #3;
        e = pc_plus4(2'b01); e.irw = 1'b1; e.nextpc = 1'b1;
        n_tests++;
        if (got !== e) begin n_fail++; $display("FAIL reset_mr1 got=%h exp=%h", got, e); end
        MemReady = 1'b0; #1;
        e = pc_plus4(2'b01);
        n_tests++;
        if (got !== e) begin n_fail++; $display("FAIL reset_mr0 got=%h exp=%h", got, e); end
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (got !== e) begin n_fail++; $display("FAIL reset_held got=%h exp=%h", got, e); end
        reset = 1'b1;
    endtask

    task automatic test_dp();
        run_instr("add_r",  2'b00, 6'b001000, 4'd1,  0, 0);
        run_instr("subs_i", 2'b00, 6'b100101, 4'd2,  0, 0);
        run_instr("cmp",    2'b00, 6'b010101, 4'd3,  0, 0);
        run_instr("orr_pc", 2'b00, 6'b011000, 4'd15, 1, 0);
        run_instr("and_s",  2'b00, 6'b000001, 4'd4,  0, 0);
        run_instr("bad_s",  2'b00, 6'b011111, 4'd15, 0, 0);
        run_instr("op11",   2'b11, 6'b000000, 4'd15, 0, 0);
    endtask

    task automatic test_mem();
        run_instr("ldr_pc", 2'b01, 6'b000001, 4'd15, 0, 2);
        run_instr("str",    2'b01, 6'b000000, 4'd15, 0, 3);
        run_instr("ldr",    2'b01, 6'b011001, 4'd5,  0, 0);
    endtask

    task automatic test_fetch_stall_branch();
        run_instr("b_fstall", 2'b10, 6'b101010, 4'd7, 5, 0);
        run_instr("b",        2'b10, 6'b000000, 4'd0, 0, 0);
    endtask

    task automatic test_reset_mid_write();
        step_t q[$];
        out_t e;
        build(2'b01, 6'b000000, 4'd2, 0, 4, q);
        Op = 2'b01; Funct = 6'b000000; Rd = 4'd2;
        // fetch, decode, memadr, first memwrite cycle
        for (int i = 0; i < 4; i++) begin
            MemReady = q[i].mr;
            @(negedge clk);
            n_tests++;
            if (got !== q[i].e) begin
                n_fail++;
                $display("FAIL rst_write cyc%0d got=%h exp=%h", i, got, q[i].e);
            end
            if (i < 3) begin @(posedge clk); #1; end
        end
        #2 reset = 1'b0;
        #1;
        e = pc_plus4(2'b01);
        n_tests++;
        if (got !== e || MemW !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_abort got=%h exp=%h", got, e);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        run_instr("after_rst", 2'b00, 6'b001001, 4'd6, 0, 0);
    endtask

    task automatic test_no_handshake();
        out_t e[5];
        reset = 1'b0;
        Op = 2'b01; Funct = 6'b000000; Rd = 4'd15; MemReady = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        e[0] = pc_plus4(2'b01); e[0].irw = 1'b1; e[0].nextpc = 1'b1;
        e[1] = pc_plus4(2'b01);
        e[2] = base(2'b01); e[2].srcb = 2'b01;
        e[3] = base(2'b01); e[3].adrsrc = 1'b1; e[3].memw = 1'b1;
        e[4] = e[0];
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_tests++;
            if (got_n !== e[i]) begin
                n_fail++;
                $display("FAIL nohs_str cyc%0d got=%h exp=%h", i, got_n, e[i]);
            end
            @(posedge clk); #1;
        end
        // re-align both instances at FETCH
        reset = 1'b0; #1; reset = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [1:0] op;
        for (int k = 0; k < 40; k++) begin
            op = 2'($urandom_range(0, 3));
            run_instr("rand", op, 6'($urandom), 4'($urandom),
                      $urandom_range(0, 3), $urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset();
        @(posedge clk); #1;
        test_dp();
        test_mem();
        test_fetch_stall_branch();
        test_reset_mid_write();
        test_no_handshake();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
